// File: rtl/gray_input_conditioner.sv
// Synchronises and debounces four raw Gray switch bits into one clean, stable vector, with a change strobe.
// Optional macro GRAY_CHECK_EN adds a multi-bit-transition error flag; when it is undefined, gray_err is tied low.
module gray_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 270000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_ag,
   input  logic sw_bg,
   input  logic sw_cg,
   input  logic sw_dg,
   output logic ag,
   output logic bg,
   output logic cg,
   output logic dg,
   output logic change,
   output logic gray_err
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t           state, state_next;
   logic [3:0]       sync1, s;
   logic [3:0]       cand, cand_next;
   logic [3:0]       stable, stable_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             change_next;

   // Two-flop synchroniser per bit; the raw pins are asynchronous to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'b0000;
         s     <= 4'b0000;
      end else begin
         sync1 <= {sw_ag, sw_bg, sw_cg, sw_dg};
         s     <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cand   <= 4'b0000;
         stable <= 4'b0000;
         cnt    <= '0;
         change <= 1'b0;
      end else begin
         state  <= state_next;
         cand   <= cand_next;
         stable <= stable_next;
         cnt    <= cnt_next;
         change <= change_next;
      end
   end

`ifdef GRAY_CHECK_EN
   logic [3:0] diff;
   logic       err_next;
   logic       err_q;

   // More than one differing bit means the diff has more than one set bit
   assign diff = stable ^ cand;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_next;
      end
   end

   assign gray_err = err_q;
`else
   assign gray_err = 1'b0;
`endif

   // A candidate is accepted only after surviving the full count with no bounce or redirect
   always_comb begin
      state_next  = state;
      cand_next   = cand;
      stable_next = stable;
      cnt_next    = cnt;
      change_next = 1'b0;
`ifdef GRAY_CHECK_EN
      err_next    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (s != stable) begin
               cand_next  = s;
               cnt_next   = '0;
               state_next = COUNT;
            end
         end
         COUNT: begin
            if (s == stable) begin
               cnt_next   = '0;
               state_next = IDLE;
            end else if (s != cand) begin
               cand_next = s;
               cnt_next  = '0;
            end else if (cnt == CNT_MAX) begin
               stable_next = cand;
               change_next = 1'b1;
               cnt_next    = '0;
               state_next  = IDLE;
`ifdef GRAY_CHECK_EN
               err_next    = ((diff & (diff - 4'd1)) != 4'd0);
`endif
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ag = stable[3];
   assign bg = stable[2];
   assign cg = stable[1];
   assign dg = stable[0];

endmodule

// File: tb/tb_gray_input_conditioner.sv
// Self-checking bench for gray_input_conditioner: table-driven steps plus hand sequences, scoreboard on change pulses.
// Honours GRAY_CHECK_EN so the expected gray_err matches the build.
module tb_gray_input_conditioner;

   localparam int N = 8;
   localparam int LAT = N + 2;

   logic clk, rst_n;
   logic sw_ag, sw_bg, sw_cg, sw_dg;
   logic ag, bg, cg, dg, change, gray_err;

   gray_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .sw_ag(sw_ag), .sw_bg(sw_bg), .sw_cg(sw_cg), .sw_dg(sw_dg),
      .ag(ag), .bg(bg), .cg(cg), .dg(dg),
      .change(change), .gray_err(gray_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sw;
      int         hold;
      bit         accept;
   } vec_t;

   typedef struct {
      logic [3:0] vec;
      bit         err;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   int         cyc = 0;
   int         asserts = 0;
   int         failures = 0;
   logic [3:0] disp_model = 4'b0000;
   logic [3:0] drv_stable = 4'b0000;
   vec_t       vectors[13];

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      asserts++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, actual, expected);
      end
   endtask

   function automatic bit modelErr(input logic [3:0] prev, input logic [3:0] next);
`ifdef GRAY_CHECK_EN
      return ($countones(prev ^ next) > 1);
`else
      return 1'b0;
`endif
   endfunction

   // Drive one switch vector just after a rising edge and register any expected acceptance
   task automatic applyStimulus(input logic [3:0] sw, input int hold, input bit accept);
      exp_t e;
      {sw_ag, sw_bg, sw_cg, sw_dg} = sw;
      if (accept) begin
         e.vec = sw;
         e.err = modelErr(drv_stable, sw);
         e.cyc = cyc + 1 + LAT;
         sb.push_back(e);
         drv_stable = sw;
      end
      repeat (hold) @(posedge clk) #1;
   endtask

   task automatic enterReset();
      rst_n = 1'b0;
      sb.delete();
      disp_model = 4'b0000;
      drv_stable = 4'b0000;
   endtask

   // Monitor on the falling edge: every change pulse must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         checkOutput("reset_out", {ag, bg, cg, dg}, 0);
         checkOutput("reset_change", change, 0);
         checkOutput("reset_err", gray_err, 0);
      end else if (change) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_change", 1, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("accept_vec", {ag, bg, cg, dg}, e.vec);
            checkOutput("accept_err", gray_err, e.err);
            checkOutput("accept_cycle", cyc, e.cyc);
            disp_model = e.vec;
         end
      end else begin
         checkOutput("hold_out", {ag, bg, cg, dg}, disp_model);
         checkOutput("idle_err", gray_err, 0);
      end
   end

   initial begin
      int guard;
      vectors[0]  = '{4'b0001, 15, 1'b1};
      vectors[1]  = '{4'b0110, 15, 1'b1};
      vectors[2]  = '{4'b0111, 15, 1'b1};
      vectors[3]  = '{4'b0101, 15, 1'b1};
      vectors[4]  = '{4'b1010, 15, 1'b1};
      vectors[5]  = '{4'b0000, 15, 1'b1};
      vectors[6]  = '{4'b0000, 12, 1'b0};
      vectors[7]  = '{4'b1000,  8, 1'b0};
      vectors[8]  = '{4'b0000, 15, 1'b0};
      vectors[9]  = '{4'b1000,  9, 1'b1};
      vectors[10] = '{4'b0000, 15, 1'b1};
      vectors[11] = '{4'b0100,  3, 1'b0};
      vectors[12] = '{4'b0000, 15, 1'b0};

      {sw_ag, sw_bg, sw_cg, sw_dg} = 4'b0000;
      enterReset();
      repeat (3) @(posedge clk) #1;
      rst_n = 1'b1;
      applyStimulus(4'b0000, 50, 1'b0);

      for (int i = 0; i < 13; i++)
         applyStimulus(vectors[i].sw, vectors[i].hold, vectors[i].accept);

      $display("[TB] bounce sequence");
      for (int i = 0; i < 10; i++)
         applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 3, 1'b0);
      applyStimulus(4'b0001, 15, 1'b1);

      $display("[TB] mid-count redirect");
      applyStimulus(4'b0000, 15, 1'b1);
      applyStimulus(4'b0001, 5, 1'b0);
      applyStimulus(4'b0011, 15, 1'b1);

      $display("[TB] reset mid-count");
      applyStimulus(4'b0000, 15, 1'b1);
      applyStimulus(4'b0010, 7, 1'b0);
      enterReset();
      repeat (2) @(posedge clk) #1;
      rst_n = 1'b1;
      applyStimulus(4'b0010, 15, 1'b1);

      guard = 0;
      while (sb.size() != 0 && guard < 40) begin
         @(posedge clk) #1;
         guard++;
      end
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
